// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch front end: owns ip, issues one segment+ip read at a time and hands words to the decoder.
// Optional fetch-limit fault checking is enabled by defining FETCH_LIMIT_CHECK_EN.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instruction_segment,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_LIMIT_CHECK_EN
  ,
  input  logic [ADDR_W-1:0] instruction_limit,
  output logic              fetch_fault
`endif
);

  typedef enum logic [2:0] {
    START,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_LIMIT_CHECK_EN
    ,
    FAULT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              ip_over;
  logic              target_over;

`ifdef FETCH_LIMIT_CHECK_EN
  assign ip_over     = (ip_q > instruction_limit);
  assign target_over = (branch_target > instruction_limit);
`else
  assign ip_over     = 1'b0;
  assign target_over = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= START;
      ip_q         <= '0;
      discard_q    <= 1'b0;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      ip_q         <= ip_d;
      discard_q    <= discard_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ip_d         = ip_q;
    discard_d    = discard_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;
    // A redirect always overrides ip; the WAIT increment below is skipped whenever a branch is present.
    if (branch_valid) ip_d = branch_target;
    case (state_q)
      START: state_d = REQ;
      REQ: begin
        if (ip_over) begin
          // An in-range redirect in the same cycle rescues the fetch instead of faulting.
          if (!(branch_valid && !target_over)) begin
`ifdef FETCH_LIMIT_CHECK_EN
            state_d = FAULT;
`endif
          end
        end else if (mem_req_ready) begin
          state_d   = WAIT;
          discard_d = branch_valid;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (branch_valid || discard_q) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            instr_data_d = mem_rsp_data;
            instr_pc_d   = ip_q;
            ip_d         = ip_q + ADDR_W'(1);
            state_d      = HOLD;
          end
        end else if (branch_valid) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready || branch_valid) state_d = REQ;
      end
`ifdef FETCH_LIMIT_CHECK_EN
      FAULT: begin
        if (branch_valid && !target_over) state_d = REQ;
      end
`endif
      default: state_d = START;
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == REQ) && !ip_over;
    mem_req_addr  = instruction_segment + ip_q;
    instr_valid   = (state_q == HOLD);
    instr_data    = instr_data_q;
    instr_pc      = instr_pc_q;
`ifdef FETCH_LIMIT_CHECK_EN
    fetch_fault   = (state_q == FAULT);
`endif
  end

endmodule
